snr_sweep_ctrl: RTL and testbench
=================================

Name: snr_sweep_ctrl

Overview:
Sequencer for the channel attenuation shifter in the Reed-Muller (1,4) test chain. On a start pulse it drives the shifter's 3-bit select code through all six valid gain settings, from -10 dB to 50 dB. At each setting it issues FRAMES_PER_STEP codeword frames to the encoder/channel/decoder path and accumulates the decoder's error reports. It emits one result record per setting over a valid/ready handshake to the host readout logic.

Parameters:
FRAMES_PER_STEP, 1024, frames run per gain setting (1..65535)
SETTLE_CYCLES, 2, idle cycles after a select change before the first frame (covers the shifter's registered output)
TIMEOUT, 4096, maximum cycles to wait for frame_done before the frame is counted as a timeout
ERR_W, 24, width of the bit-error accumulator

Ports:
clk  in  1  system clock; all logic on posedge
rst_n  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse; begins a sweep, honoured only in IDLE
abort  in  1  level; forces return to IDLE
atten_sel  out  3  select code to the shifter
frame_start  out  1  one-cycle pulse; launches one frame
frame_done  in  1  one-cycle pulse; the decoder has finished the current frame
frame_bit_errs  in  5  bit errors in the finished frame (0..16), valid with frame_done
res_valid  out  1  result record valid
res_ready  in  1  consumer accepts the record
res_step  out  3  step index 0..5
res_sel  out  3  select code used for this step
res_bit_errs  out  ERR_W  accumulated bit errors for the step
res_frame_errs  out  16  frames with nonzero bit errors
res_timeouts  out  16  frames that timed out
busy  out  1  high whenever not in IDLE
done  out  1  one-cycle pulse after the last record is accepted

Behaviour:
- Reset (async, rst_n=0) puts the block in IDLE with these output values:
  - atten_sel=3'b111 (bypass, 50 dB)
  - frame_start, res_valid, busy, done = 0
  - all res_* fields = 0
  - all counters = 0
- Step table, in order: step0=000, step1=001, step2=010, step3=100, step4=101, step5=111. Codes 011 and 110 are never driven.
- IDLE, start=1: load step=0, drive atten_sel=000, clear accumulators, go to SETTLE.
- SETTLE: count SETTLE_CYCLES cycles, then go to ISSUE.
- ISSUE: assert frame_start for exactly one cycle, clear the timeout counter, go to WAIT.
- WAIT: the timeout counter increments each cycle.
  - frame_done=1: add frame_bit_errs to res_bit_errs (saturating at 2^ERR_W-1); if frame_bit_errs!=0, increment res_frame_errs (saturating at 16'hFFFF).
  - Counter reaches TIMEOUT-1 with no frame_done: increment res_timeouts (saturating).
  - frame_done and timeout expiry in the same cycle: the done wins and no timeout is counted.
  - After either event, increment the frame counter. If the frame counter equals FRAMES_PER_STEP go to REPORT, else go to ISSUE.
  - The next frame_start therefore follows the completing event by exactly 1 cycle.
- frame_done outside WAIT is ignored.
- REPORT: res_valid=1. All res_* fields are held stable until res_ready=1 in the same cycle.
  - On acceptance: res_valid drops next cycle.
  - If step<5: step increments, atten_sel is updated, accumulators clear, go to SETTLE.
  - If step=5: go to DONE.
- DONE: pulse done for one cycle, set atten_sel=111, go to IDLE.
- abort=1 in any state: next cycle is IDLE, with the reset output values except the res_* fields, which hold their last values.
  - Any pending record is dropped; res_valid falls.
  - abort has priority over start and over frame_done.
- start while busy: ignored.
- frame_start is never asserted while res_valid=1.
- Latency for a full sweep with no timeouts, where L is the frame_done latency in cycles and R is the res_ready wait in cycles: 6*(SETTLE_CYCLES + FRAMES_PER_STEP*(L+1) + 1 + R) + 1 cycles.

Test Plan:
1. FRAMES_PER_STEP=4, decoder model returns frame_done 3 cycles after frame_start with bit_errs=0, res_ready tied high -> six records:
   - res_sel = 000,001,010,100,101,111
   - all error counts 0
   - done pulses once; atten_sel returns to 111; busy falls
2. bit_errs sequence 0,3,16,1 in step 2 -> that record has res_bit_errs=20, res_frame_errs=3, res_timeouts=0; the other steps are unaffected.
3. TIMEOUT=16, decoder silent for the 2nd frame of step 0 -> res_timeouts=1, and the next frame_start occurs exactly 16 cycles after the preceding frame_start.
4. frame_done coincident with timeout expiry -> timeout is not counted; bit errors are accumulated.
5. res_ready held low for 50 cycles in step 1 -> res_valid stays high with stable fields, no frame_start and no atten_sel change; the sweep proceeds after acceptance.
6. abort asserted during WAIT of step 3; second case with rst_n pulsed low mid-sweep; then a new start:
   - After abort: IDLE next cycle with atten_sel=111, busy=0, res_valid=0.
   - After rst_n: all outputs at reset values immediately.
   - The new start restarts the sweep at sel=000 with cleared counts.

Source files
------------

// File: rtl/snr_sweep_ctrl.sv
// SNR sweep sequencer for the RM(1,4) test chain.
// Walks the attenuation shifter through its six gain codes, runs a fixed
// number of frames per code, accumulates decoder error reports and hands
// one result record per code to the host over a valid/ready handshake.
module snr_sweep_ctrl #(
   parameter int FRAMES_PER_STEP = 1024,  // 1..65535
   parameter int SETTLE_CYCLES   = 2,     // minimum 1
   parameter int TIMEOUT         = 4096,  // minimum 2
   parameter int ERR_W           = 24
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             abort,
   output logic [2:0]       atten_sel,
   output logic             frame_start,
   input  logic             frame_done,
   input  logic [4:0]       frame_bit_errs,
   output logic             res_valid,
   input  logic             res_ready,
   output logic [2:0]       res_step,
   output logic [2:0]       res_sel,
   output logic [ERR_W-1:0] res_bit_errs,
   output logic [15:0]      res_frame_errs,
   output logic [15:0]      res_timeouts,
   output logic             busy,
   output logic             done
);

   localparam int TW = $clog2(TIMEOUT + 1);
   localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

   typedef enum logic [2:0] {
      S_IDLE, S_SETTLE, S_ISSUE, S_WAIT, S_REPORT, S_DONE
   } state_t;

   state_t          state;
   logic [2:0]      step;
   logic [SW-1:0]   scnt;
   logic [15:0]     fcnt;
   logic [TW-1:0]   to_cnt;   // cycles elapsed since the current frame_start

   // Gain table; codes 011 and 110 are not valid shifter settings.
   function automatic logic [2:0] step_code(input logic [2:0] s);
      case (s)
         3'd0:    step_code = 3'b000;
         3'd1:    step_code = 3'b001;
         3'd2:    step_code = 3'b010;
         3'd3:    step_code = 3'b100;
         3'd4:    step_code = 3'b101;
         default: step_code = 3'b111;
      endcase
   endfunction

   logic [ERR_W:0]   bit_sum;
   logic [ERR_W-1:0] bit_next;
   logic [15:0]      ferr_next;
   logic [15:0]      to_next;
   logic             to_exp;
   logic             last_frame;
   logic [2:0]       step_inc;

   // Saturating accumulator updates and frame/timeout terminal conditions
   assign bit_sum    = {1'b0, res_bit_errs} + (ERR_W+1)'(frame_bit_errs);
   assign bit_next   = bit_sum[ERR_W] ? '1 : bit_sum[ERR_W-1:0];
   assign ferr_next  = (res_frame_errs == 16'hFFFF) ? res_frame_errs : res_frame_errs + 16'd1;
   assign to_next    = (res_timeouts == 16'hFFFF) ? res_timeouts : res_timeouts + 16'd1;
   assign to_exp     = (to_cnt == TW'(TIMEOUT - 1));
   assign last_frame = (fcnt == 16'(FRAMES_PER_STEP - 1));
   assign step_inc   = step + 3'd1;

   // Sweep FSM with registered outputs; abort outranks every other input
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state          <= S_IDLE;
         step           <= '0;
         scnt           <= '0;
         fcnt           <= '0;
         to_cnt         <= '0;
         atten_sel      <= 3'b111;
         frame_start    <= 1'b0;
         res_valid      <= 1'b0;
         res_step       <= '0;
         res_sel        <= '0;
         res_bit_errs   <= '0;
         res_frame_errs <= '0;
         res_timeouts   <= '0;
         busy           <= 1'b0;
         done           <= 1'b0;
      end else if (abort) begin
         // Result fields keep their last values so the host can inspect them.
         state       <= S_IDLE;
         step        <= '0;
         scnt        <= '0;
         fcnt        <= '0;
         to_cnt      <= '0;
         atten_sel   <= 3'b111;
         frame_start <= 1'b0;
         res_valid   <= 1'b0;
         busy        <= 1'b0;
         done        <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (start) begin
                  step           <= '0;
                  scnt           <= '0;
                  fcnt           <= '0;
                  atten_sel      <= step_code(3'd0);
                  res_step       <= '0;
                  res_sel        <= step_code(3'd0);
                  res_bit_errs   <= '0;
                  res_frame_errs <= '0;
                  res_timeouts   <= '0;
                  busy           <= 1'b1;
                  state          <= S_SETTLE;
               end
            end
            S_SETTLE: begin
               if (scnt == SW'(SETTLE_CYCLES - 1)) begin
                  scnt        <= '0;
                  frame_start <= 1'b1;
                  state       <= S_ISSUE;
               end else begin
                  scnt <= scnt + 1'b1;
               end
            end
            S_ISSUE: begin
               frame_start <= 1'b0;
               to_cnt      <= TW'(1);
               state       <= S_WAIT;
            end
            S_WAIT: begin
               if (frame_done || to_exp) begin
                  // A report landing on the expiry cycle still counts as a report.
                  if (frame_done) begin
                     res_bit_errs <= bit_next;
                     if (frame_bit_errs != 5'd0)
                        res_frame_errs <= ferr_next;
                  end else begin
                     res_timeouts <= to_next;
                  end
                  to_cnt <= '0;
                  if (last_frame) begin
                     fcnt      <= '0;
                     res_valid <= 1'b1;
                     state     <= S_REPORT;
                  end else begin
                     fcnt        <= fcnt + 16'd1;
                     frame_start <= 1'b1;
                     state       <= S_ISSUE;
                  end
               end else begin
                  to_cnt <= to_cnt + 1'b1;
               end
            end
            S_REPORT: begin
               if (res_ready) begin
                  res_valid <= 1'b0;
                  if (step == 3'd5) begin
                     done      <= 1'b1;
                     atten_sel <= 3'b111;
                     state     <= S_DONE;
                  end else begin
                     step           <= step_inc;
                     atten_sel      <= step_code(step_inc);
                     res_step       <= step_inc;
                     res_sel        <= step_code(step_inc);
                     res_bit_errs   <= '0;
                     res_frame_errs <= '0;
                     res_timeouts   <= '0;
                     scnt           <= '0;
                     state          <= S_SETTLE;
                  end
               end
            end
            S_DONE: begin
               done  <= 1'b0;
               busy  <= 1'b0;
               state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_snr_sweep_ctrl.sv
// Directed bench for snr_sweep_ctrl: a negedge environment process plays the
// decoder and the host, logging records; scenario tasks check against
// hand-computed values.
module tb_snr_sweep_ctrl;

   localparam int F   = 4;
   localparam int S   = 2;
   localparam int TO  = 16;
   localparam int EW  = 24;
   localparam int NFR = 6 * F;

   logic          clk = 1'b0;
   logic          rst_n = 1'b1;
   logic          start = 1'b0;
   logic          abort = 1'b0;
   logic          frame_done = 1'b0;
   logic [4:0]    frame_bit_errs = 5'd0;
   logic          res_ready = 1'b1;
   logic [2:0]    atten_sel;
   logic          frame_start;
   logic          res_valid;
   logic [2:0]    res_step;
   logic [2:0]    res_sel;
   logic [EW-1:0] res_bit_errs;
   logic [15:0]   res_frame_errs;
   logic [15:0]   res_timeouts;
   logic          busy;
   logic          done;

   snr_sweep_ctrl #(
      .FRAMES_PER_STEP(F), .SETTLE_CYCLES(S), .TIMEOUT(TO), .ERR_W(EW)
   ) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
      .atten_sel(atten_sel), .frame_start(frame_start),
      .frame_done(frame_done), .frame_bit_errs(frame_bit_errs),
      .res_valid(res_valid), .res_ready(res_ready),
      .res_step(res_step), .res_sel(res_sel),
      .res_bit_errs(res_bit_errs), .res_frame_errs(res_frame_errs),
      .res_timeouts(res_timeouts), .busy(busy), .done(done)
   );

   initial begin
      forever #5 clk = ~clk;
   end

   int checks = 0;
   int fails  = 0;

   // Stimulus tables: decoder latency (0 = silent) and errors per sweep frame,
   // host ready delay per step.
   int lat_t [NFR];
   int err_t [NFR];
   int rdly  [8];
   logic [2:0] exp_sel [6];

   // Environment state and logs
   int cyc = 0, fidx = 0, dcnt = 0, cur_err = 0, rw = 0;
   int nrec = 0, ndone = 0, viol = 0, done_viol = 0;
   int fs_cyc [32];
   logic prev_done = 1'b0;
   logic [2:0]    rec_step [128];
   logic [2:0]    rec_sel  [128];
   logic [EW-1:0] rec_bit  [128];
   logic [15:0]   rec_ferr [128];
   logic [15:0]   rec_to   [128];

   // Decoder model, host model and record logger, all on the falling edge
   initial begin
      forever begin
         @(negedge clk);
         cyc++;
         if (busy !== 1'b1) begin
            fidx = 0;
            dcnt = 0;
         end
         frame_done = 1'b0;
         frame_bit_errs = 5'd0;
         if (dcnt > 0) begin
            dcnt--;
            if (dcnt == 0) begin
               frame_done = 1'b1;
               frame_bit_errs = 5'(cur_err);
            end
         end
         if (frame_start === 1'b1) begin
            if (res_valid === 1'b1) viol++;
            if (fidx < 32) fs_cyc[fidx] = cyc;
            if (fidx < NFR) begin
               dcnt = lat_t[fidx];
               cur_err = err_t[fidx];
            end else begin
               dcnt = 0;
            end
            fidx++;
         end
         if (res_valid === 1'b1) begin
            if (rw < rdly[res_step]) begin
               res_ready = 1'b0;
               rw++;
            end else begin
               res_ready = 1'b1;
               rw = 0;
               if (nrec < 128) begin
                  rec_step[nrec] = res_step;
                  rec_sel[nrec]  = res_sel;
                  rec_bit[nrec]  = res_bit_errs;
                  rec_ferr[nrec] = res_frame_errs;
                  rec_to[nrec]   = res_timeouts;
               end
               nrec++;
            end
         end else begin
            res_ready = 1'b1;
            rw = 0;
         end
         if (done === 1'b1 && prev_done) done_viol++;
         if (done === 1'b1) ndone++;
         prev_done = (done === 1'b1);
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic clear_tables();
      for (int i = 0; i < NFR; i++) begin
         lat_t[i] = 3;
         err_t[i] = 0;
      end
      for (int i = 0; i < 8; i++) rdly[i] = 0;
   endtask

   // Pulse start and count the cycles busy stays high (bounded).
   task automatic run_sweep(output int n);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      n = 0;
      while (busy === 1'b1 && n < 2000) begin
         @(negedge clk);
         n++;
      end
   endtask

   task automatic test_reset();
      repeat (2) @(negedge clk);
      checks++; if (atten_sel !== 3'b111) begin fails++; $display("FAIL reset_atten: got %b want 111", atten_sel); end
      checks++; if ({frame_start, res_valid, busy, done} !== 4'b0) begin fails++; $display("FAIL reset_ctl: got %b want 0000", {frame_start, res_valid, busy, done}); end
      checks++; if ({res_step, res_sel} !== 6'd0) begin fails++; $display("FAIL reset_step_sel: got %b want 0", {res_step, res_sel}); end
      checks++; if (res_bit_errs !== '0 || res_frame_errs !== '0 || res_timeouts !== '0) begin fails++; $display("FAIL reset_counts: got %0d/%0d/%0d want 0", res_bit_errs, res_frame_errs, res_timeouts); end
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      checks++; if (busy !== 1'b0 || atten_sel !== 3'b111) begin fails++; $display("FAIL reset_release: busy %b atten %b want 0/111", busy, atten_sel); end
   endtask

   task automatic test_clean_sweep();
      int n, base, d0;
      clear_tables();
      base = nrec; d0 = ndone;
      run_sweep(n);
      checks++; if (n !== 115) begin fails++; $display("FAIL clean_latency: got %0d want 115", n); end
      checks++; if (nrec - base !== 6) begin fails++; $display("FAIL clean_nrec: got %0d want 6", nrec - base); end
      for (int k = 0; k < 6; k++) begin
         checks++; if (rec_sel[base+k] !== exp_sel[k]) begin fails++; $display("FAIL clean_sel%0d: got %b want %b", k, rec_sel[base+k], exp_sel[k]); end
         checks++; if (rec_step[base+k] !== 3'(k)) begin fails++; $display("FAIL clean_step%0d: got %0d want %0d", k, rec_step[base+k], k); end
         checks++; if (rec_bit[base+k] !== '0 || rec_ferr[base+k] !== '0 || rec_to[base+k] !== '0) begin fails++; $display("FAIL clean_counts%0d: got %0d/%0d/%0d want 0", k, rec_bit[base+k], rec_ferr[base+k], rec_to[base+k]); end
      end
      checks++; if (ndone - d0 !== 1 || done_viol !== 0) begin fails++; $display("FAIL clean_done: pulses %0d long %0d want 1/0", ndone - d0, done_viol); end
      checks++; if (atten_sel !== 3'b111 || busy !== 1'b0) begin fails++; $display("FAIL clean_end: atten %b busy %b want 111/0", atten_sel, busy); end
      checks++; if (viol !== 0) begin fails++; $display("FAIL clean_fs_vs_valid: got %0d want 0", viol); end
   endtask

   task automatic test_bit_errs();
      int n, base;
      logic [EW-1:0] eb;
      logic [15:0] ef;
      clear_tables();
      err_t[8] = 0; err_t[9] = 3; err_t[10] = 16; err_t[11] = 1;
      base = nrec;
      run_sweep(n);
      checks++; if (n !== 115) begin fails++; $display("FAIL errs_latency: got %0d want 115", n); end
      for (int k = 0; k < 6; k++) begin
         eb = (k == 2) ? EW'(20) : '0;
         ef = (k == 2) ? 16'd3 : 16'd0;
         checks++; if (rec_bit[base+k] !== eb) begin fails++; $display("FAIL errs_bit%0d: got %0d want %0d", k, rec_bit[base+k], eb); end
         checks++; if (rec_ferr[base+k] !== ef) begin fails++; $display("FAIL errs_ferr%0d: got %0d want %0d", k, rec_ferr[base+k], ef); end
         checks++; if (rec_to[base+k] !== 16'd0) begin fails++; $display("FAIL errs_to%0d: got %0d want 0", k, rec_to[base+k]); end
      end
   endtask

   task automatic test_timeout();
      int n, base;
      logic [15:0] et;
      clear_tables();
      lat_t[1] = 0;
      base = nrec;
      run_sweep(n);
      checks++; if (n !== 127) begin fails++; $display("FAIL to_latency: got %0d want 127", n); end
      checks++; if (fs_cyc[1] - fs_cyc[0] !== 4) begin fails++; $display("FAIL to_normal_gap: got %0d want 4", fs_cyc[1] - fs_cyc[0]); end
      checks++; if (fs_cyc[2] - fs_cyc[1] !== 16) begin fails++; $display("FAIL to_gap: got %0d want 16", fs_cyc[2] - fs_cyc[1]); end
      for (int k = 0; k < 6; k++) begin
         et = (k == 0) ? 16'd1 : 16'd0;
         checks++; if (rec_to[base+k] !== et) begin fails++; $display("FAIL to_count%0d: got %0d want %0d", k, rec_to[base+k], et); end
         checks++; if (rec_bit[base+k] !== '0 || rec_ferr[base+k] !== '0) begin fails++; $display("FAIL to_errs%0d: got %0d/%0d want 0", k, rec_bit[base+k], rec_ferr[base+k]); end
      end
   endtask

   task automatic test_coincident();
      int n, base;
      clear_tables();
      lat_t[13] = TO - 1;
      err_t[13] = 5;
      base = nrec;
      run_sweep(n);
      checks++; if (n !== 127) begin fails++; $display("FAIL coin_latency: got %0d want 127", n); end
      checks++; if (fs_cyc[14] - fs_cyc[13] !== 16) begin fails++; $display("FAIL coin_gap: got %0d want 16", fs_cyc[14] - fs_cyc[13]); end
      checks++; if (rec_to[base+3] !== 16'd0) begin fails++; $display("FAIL coin_to: got %0d want 0", rec_to[base+3]); end
      checks++; if (rec_bit[base+3] !== EW'(5)) begin fails++; $display("FAIL coin_bit: got %0d want 5", rec_bit[base+3]); end
      checks++; if (rec_ferr[base+3] !== 16'd1) begin fails++; $display("FAIL coin_ferr: got %0d want 1", rec_ferr[base+3]); end
   endtask

   task automatic test_backpressure();
      int n, base;
      clear_tables();
      rdly[1] = 50;
      base = nrec;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      n = 0;
      while (!(res_valid === 1'b1 && res_step === 3'd1) && n < 500) begin
         @(negedge clk);
         n++;
      end
      checks++; if (n >= 500) begin fails++; $display("FAIL bp_reach_step1: got timeout after %0d cycles want record", n); end
      for (int i = 1; i <= 48; i++) begin
         start = (i == 10) ? 1'b1 : 1'b0;
         @(negedge clk);
         n++;
         checks++; if (res_valid !== 1'b1 || frame_start !== 1'b0) begin fails++; $display("FAIL bp_hold%0d: valid %b fs %b want 1/0", i, res_valid, frame_start); end
         checks++; if (res_step !== 3'd1 || res_sel !== 3'b001 || atten_sel !== 3'b001) begin fails++; $display("FAIL bp_fields%0d: step %0d sel %b atten %b want 1/001/001", i, res_step, res_sel, atten_sel); end
         checks++; if (res_bit_errs !== '0 || res_frame_errs !== '0 || res_timeouts !== '0) begin fails++; $display("FAIL bp_counts%0d: got %0d/%0d/%0d want 0", i, res_bit_errs, res_frame_errs, res_timeouts); end
      end
      start = 1'b0;
      while (busy === 1'b1 && n < 2000) begin
         @(negedge clk);
         n++;
      end
      checks++; if (n !== 165) begin fails++; $display("FAIL bp_latency: got %0d want 165", n); end
      checks++; if (nrec - base !== 6) begin fails++; $display("FAIL bp_nrec: got %0d want 6", nrec - base); end
      for (int k = 0; k < 6; k++) begin
         checks++; if (rec_sel[base+k] !== exp_sel[k]) begin fails++; $display("FAIL bp_sel%0d: got %b want %b", k, rec_sel[base+k], exp_sel[k]); end
      end
   endtask

   task automatic test_abort();
      int n, base;
      clear_tables();
      err_t[12] = 7;
      base = nrec;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      n = 0;
      while (fidx < 14 && n < 1000) begin
         @(negedge clk);
         n++;
      end
      checks++; if (n >= 1000) begin fails++; $display("FAIL ab_reach_step3: timeout after %0d cycles", n); end
      @(negedge clk);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      checks++; if (atten_sel !== 3'b111 || busy !== 1'b0 || res_valid !== 1'b0) begin fails++; $display("FAIL ab_idle: atten %b busy %b valid %b want 111/0/0", atten_sel, busy, res_valid); end
      checks++; if (frame_start !== 1'b0 || done !== 1'b0) begin fails++; $display("FAIL ab_pulses: fs %b done %b want 0/0", frame_start, done); end
      checks++; if (res_step !== 3'd3 || res_sel !== 3'b100) begin fails++; $display("FAIL ab_hold_sel: step %0d sel %b want 3/100", res_step, res_sel); end
      checks++; if (res_bit_errs !== EW'(7) || res_frame_errs !== 16'd1 || res_timeouts !== 16'd0) begin fails++; $display("FAIL ab_hold_counts: got %0d/%0d/%0d want 7/1/0", res_bit_errs, res_frame_errs, res_timeouts); end
      checks++; if (nrec - base !== 3) begin fails++; $display("FAIL ab_nrec: got %0d want 3", nrec - base); end
      start = 1'b1;
      abort = 1'b1;
      @(negedge clk);
      start = 1'b0;
      abort = 1'b0;
      @(negedge clk);
      checks++; if (busy !== 1'b0 || atten_sel !== 3'b111) begin fails++; $display("FAIL ab_priority: busy %b atten %b want 0/111", busy, atten_sel); end
      clear_tables();
      base = nrec;
      run_sweep(n);
      checks++; if (n !== 115) begin fails++; $display("FAIL ab_restart_latency: got %0d want 115", n); end
      for (int k = 0; k < 6; k++) begin
         checks++; if (rec_sel[base+k] !== exp_sel[k]) begin fails++; $display("FAIL ab_restart_sel%0d: got %b want %b", k, rec_sel[base+k], exp_sel[k]); end
         checks++; if (rec_bit[base+k] !== '0 || rec_ferr[base+k] !== '0 || rec_to[base+k] !== '0) begin fails++; $display("FAIL ab_restart_counts%0d: got %0d/%0d/%0d want 0", k, rec_bit[base+k], rec_ferr[base+k], rec_to[base+k]); end
      end
   endtask

   task automatic test_reset_mid();
      int n, base;
      clear_tables();
      err_t[6] = 2;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      n = 0;
      while (fidx < 8 && n < 1000) begin
         @(negedge clk);
         n++;
      end
      checks++; if (n >= 1000) begin fails++; $display("FAIL rm_reach_step1: timeout after %0d cycles", n); end
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      checks++; if (atten_sel !== 3'b111) begin fails++; $display("FAIL rm_atten: got %b want 111", atten_sel); end
      checks++; if ({frame_start, res_valid, busy, done} !== 4'b0) begin fails++; $display("FAIL rm_ctl: got %b want 0000", {frame_start, res_valid, busy, done}); end
      checks++; if ({res_step, res_sel} !== 6'd0) begin fails++; $display("FAIL rm_step_sel: got %b want 0", {res_step, res_sel}); end
      checks++; if (res_bit_errs !== '0 || res_frame_errs !== '0 || res_timeouts !== '0) begin fails++; $display("FAIL rm_counts: got %0d/%0d/%0d want 0", res_bit_errs, res_frame_errs, res_timeouts); end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      clear_tables();
      base = nrec;
      run_sweep(n);
      checks++; if (n !== 115) begin fails++; $display("FAIL rm_restart_latency: got %0d want 115", n); end
      checks++; if (nrec - base !== 6) begin fails++; $display("FAIL rm_nrec: got %0d want 6", nrec - base); end
      for (int k = 0; k < 6; k++) begin
         checks++; if (rec_sel[base+k] !== exp_sel[k]) begin fails++; $display("FAIL rm_sel%0d: got %b want %b", k, rec_sel[base+k], exp_sel[k]); end
         checks++; if (rec_bit[base+k] !== '0 || rec_ferr[base+k] !== '0 || rec_to[base+k] !== '0) begin fails++; $display("FAIL rm_counts%0d: got %0d/%0d/%0d want 0", k, rec_bit[base+k], rec_ferr[base+k], rec_to[base+k]); end
      end
      checks++; if (viol !== 0 || done_viol !== 0) begin fails++; $display("FAIL rm_protocol: fs_vs_valid %0d long_done %0d want 0/0", viol, done_viol); end
   endtask

   initial begin
      exp_sel[0] = 3'b000; exp_sel[1] = 3'b001; exp_sel[2] = 3'b010;
      exp_sel[3] = 3'b100; exp_sel[4] = 3'b101; exp_sel[5] = 3'b111;
      clear_tables();
      #1 rst_n = 1'b0;
      test_reset();
      test_clean_sweep();
      test_bit_errs();
      test_timeout();
      test_coincident();
      test_backpressure();
      test_abort();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
